hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage MIPS core.
- Generates the PC write enable, the IF/ID register stall and flush, and the ID/EX bubble (flush).
- Handles three cases: load-use hazards, taken branches/jumps resolved in ID, and multi-cycle EX operations (mult/div) that occupy EX for a fixed number of cycles.
- Sits beside the ID stage; drives the stall/flush inputs of IF/ID and ID/EX and the PC register enable.

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/hazard_detect.sv | 27 ++
 rtl/hazard_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the 5-stage core's hazard logic.
//   hz_state_e : hazard FSM state encoding (RUN / MC_BUSY)
//   hz_ctrl_t  : bundle of pipeline control strobes driven by hazard_ctrl
//   REG_ZERO   : architectural $zero, never a real dependency
//   MC_CYCLES_DEF / CNT_W_DEF : default parameter values
package pipeline_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_flush;
    logic mc_busy;
  } hz_ctrl_t;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         MC_CYCLES_DEF = 4;
  localparam int         CNT_W_DEF     = 16;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector. Flags when the instruction in ID reads a
// register that the load currently in EX will write. Kept separate so the
// forwarding unit can reuse the same compare.
//   id_rs/id_rt         : source fields of the ID instruction
//   id_uses_rs/_rt      : ID instruction actually reads that field
//   ex_memread, ex_rt   : EX holds a load targeting ex_rt
//   load_use            : one-cycle stall required
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  logic rs_hit, rt_hit;

  assign rs_hit   = id_uses_rs && (id_rs == ex_rt);
  assign rt_hit   = id_uses_rt && (id_rt == ex_rt);
  // Writes to $zero are discarded, so they never create a dependency.
  assign load_use = ex_memread && (ex_rt != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller sitting beside ID. Resolves load-use stalls,
// taken branch/jump flushes and multi-cycle (mult/div) EX occupancy, and
// counts cycles in which the PC was held.
//   clk, rst_n          : clock, synchronous active-low reset
//   id_*                : ID-stage instruction info
//   ex_memread, ex_rt   : load in EX
//   pc_write            : PC register enable
//   ifid_stall/_flush   : hold / zero IF/ID
//   idex_flush          : bubble into ID/EX
//   mc_busy             : multi-cycle op occupying EX
//   stall_cnt           : saturating count of pc_write=0 cycles
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MC_CYCLES = MC_CYCLES_DEF,  // 1..15
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_mc_start,
  input  logic             id_branch_taken,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  output logic             pc_write,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Entry value so that the busy phase spans MC_CYCLES cycles ending at 0.
  localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 1);

  hz_state_e        state_q, state_d;
  logic [3:0]       mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  hz_ctrl_t         ctrl;
  logic             load_use;

  hazard_detect u_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .load_use   (load_use)
  );

  always_comb begin
    state_d         = state_q;
    mc_cnt_d        = mc_cnt_q;
    ctrl            = '0;
    ctrl.pc_write   = 1'b1;
    case (state_q)
      RUN: begin
        if (load_use) begin
          // Load-use outranks branch/mc: the instruction is replayed next
          // cycle and re-presents its branch/mc request then.
          ctrl.pc_write   = 1'b0;
          ctrl.ifid_stall = 1'b1;
          ctrl.idex_flush = 1'b1;
        end else if (id_branch_taken) begin
          ctrl.ifid_flush = 1'b1;
        end else if (id_mc_start) begin
          // The mc op itself issues this cycle; the hold starts next cycle.
          state_d  = MC_BUSY;
          mc_cnt_d = MC_LOAD;
        end
      end
      MC_BUSY: begin
        ctrl.pc_write   = 1'b0;
        ctrl.ifid_stall = 1'b1;
        ctrl.idex_flush = 1'b1;
        ctrl.mc_busy    = 1'b1;
        if (mc_cnt_q == 4'd0) state_d  = RUN;
        else                  mc_cnt_d = mc_cnt_q - 4'd1;
      end
      default: state_d = RUN;
    endcase
    // Reset overrides everything: keep the front end flushed and PC frozen.
    if (!rst_n) begin
      ctrl            = '0;
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ctrl.pc_write && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      mc_cnt_q    <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_write   = ctrl.pc_write;
  assign ifid_stall = ctrl.ifid_stall;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_flush = ctrl.idex_flush;
  assign mc_busy    = ctrl.mc_busy;
  assign stall_cnt  = stall_cnt_q;

endmodule
